// File: rtl/stopwatch_pkg.sv
// Shared types, constants and helpers for the stopwatch core.
// Optional feature macro: STOPWATCH_DEBOUNCE_EN (consumed in stopwatch_btn_cond).
package stopwatch_pkg;

    // Control FSM state (2-bit)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [7:0]  BCD_MAX     = 8'h99;
    localparam logic [7:0]  BCD_ZERO    = 8'h00;

    // Two-digit BCD increment with 99 -> 00 wrap; never yields a non-BCD digit
    function automatic logic [7:0] bcd8_inc(input logic [7:0] value);
        logic [BCD_DIGIT_W-1:0] units;
        logic [BCD_DIGIT_W-1:0] tens;
        units = value[BCD_DIGIT_W-1:0];
        tens  = value[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        if (value == BCD_MAX) begin
            units = '0;
            tens  = '0;
        end else if (units >= BCD_DIGIT_W'(9)) begin
            units = '0;
            if (tens >= BCD_DIGIT_W'(9)) begin
                tens = '0;
            end else begin
                tens = tens + BCD_DIGIT_W'(1);
            end
        end else begin
            units = units + BCD_DIGIT_W'(1);
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/stopwatch_btn_cond.sv
// Button conditioner: 2-FF synchroniser, optional debouncer, rising-edge
// detect producing a registered 1-cycle press pulse.
// Optional feature macro: STOPWATCH_DEBOUNCE_EN (adds the debouncer).
module stopwatch_btn_cond
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    // Synchroniser; resets to "pressed" so a button held through reset
    // must be released before it can produce a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] stable_cnt;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b1;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_debounce_cfg;

    assign level               = sync2;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
`endif

    // Rising-edge detect on the accepted level, registered pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch control core: button conditioning, IDLE/RUN/PAUSE/LAP FSM,
// tick divider, 2-digit BCD counter, lap snapshot/hold and display register.
// Optional feature macro: STOPWATCH_DEBOUNCE_EN (button debouncers).
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 800000,
    parameter int unsigned LAP_HOLD_TICKS  = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [7:0] dout,
    output logic       running,
    output logic       lap_active
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned LAP_W = 5;

    sw_state_t        state;
    sw_state_t        state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             counting;
    logic             tick;
    logic [7:0]       count;
    logic [7:0]       count_nxt;
    logic [7:0]       snap;
    logic [7:0]       snap_nxt;
    logic [LAP_W-1:0] lap_left;
    logic [LAP_W-1:0] lap_left_nxt;
    logic             ss_press;
    logic             lap_press;
    logic             clear_press;

    stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start_stop),
        .press (ss_press)
    );

    stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lap),
        .press (lap_press)
    );

    stopwatch_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .press (clear_press)
    );

    assign counting   = (state == ST_RUN) || (state == ST_LAP);
    assign tick       = counting && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign running    = counting;
    assign lap_active = (state == ST_LAP);

    // Tick divider: free-runs only while counting, held at zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!counting || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Next-state: clear overrides all; start_stop overrides lap; the count
    // advances on a tick independently of any state change in that cycle
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        snap_nxt     = snap;
        lap_left_nxt = lap_left;
        if (clear_press) begin
            state_nxt    = ST_IDLE;
            count_nxt    = BCD_ZERO;
            lap_left_nxt = '0;
        end else begin
            if (tick) begin
                count_nxt = bcd8_inc(count);
            end
            case (state)
                ST_IDLE: begin
                    if (ss_press) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ss_press) begin
                        state_nxt = ST_PAUSE;
                    end else if (lap_press) begin
                        state_nxt    = ST_LAP;
                        snap_nxt     = count;
                        lap_left_nxt = LAP_W'(LAP_HOLD_TICKS);
                    end
                end
                ST_PAUSE: begin
                    if (ss_press) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_LAP: begin
                    if (ss_press) begin
                        state_nxt    = ST_PAUSE;
                        lap_left_nxt = '0;
                    end else if (lap_press) begin
                        snap_nxt     = count;
                        lap_left_nxt = LAP_W'(LAP_HOLD_TICKS);
                    end else if (tick) begin
                        lap_left_nxt = lap_left - LAP_W'(1);
                        if (lap_left == LAP_W'(1)) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, counter, snapshot and lap-timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= BCD_ZERO;
            snap     <= BCD_ZERO;
            lap_left <= '0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            snap     <= snap_nxt;
            lap_left <= lap_left_nxt;
        end
    end

    // Display register: snapshot during a lap hold, live count otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= BCD_ZERO;
        end else begin
            dout <= (state == ST_LAP) ? snap : count;
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Self-checking bench for stopwatch_timer (TICK_DIV=4, LAP_HOLD_TICKS=3,
// DEBOUNCE_CYCLES=8). Directed scenarios plus randomized button activity
// compared against a decimal-arithmetic reference model.
module tb_stopwatch_timer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned HOLD     = 3;
    localparam int unsigned DEB      = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_ss = 1'b0;
    logic       b_lp = 1'b0;
    logic       b_cl = 1'b0;
    logic [7:0] dout;
    logic       running;
    logic       lap_active;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_timer #(
        .TICK_DIV        (TICK_DIV),
        .LAP_HOLD_TICKS  (HOLD),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (b_ss),
        .btn_lap        (b_lp),
        .btn_clear      (b_cl),
        .dout           (dout),
        .running        (running),
        .lap_active     (lap_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; leaves time 1 unit after the active edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic l, input logic c);
        b_ss = s;
        b_lp = l;
        b_cl = c;
        cyc(2);
        b_ss = 1'b0;
        b_lp = 1'b0;
        b_cl = 1'b0;
    endtask

    task automatic wait_run(input string tag, input logic want, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (running === want) break;
            cyc(1);
        end
        check(tag, running, want);
    endtask

    task automatic wait_dout(input string tag, input logic [7:0] v, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (dout === v) break;
            cyc(1);
        end
        check(tag, dout, v);
    endtask

    task automatic wait_change(input logic [7:0] old, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (dout !== old) break;
            cyc(1);
        end
    endtask

`ifndef STOPWATCH_DEBOUNCE_EN
    // Reference model: count kept as a decimal integer, presses derived from
    // the raw level seen 3 and 4 clocks earlier (levels before reset read as 1)
    int       m_mode;   // 0 idle, 1 run, 2 pause, 3 lap
    int       m_count;
    int       m_phase;
    int       m_left;
    int       m_snap;
    int       exp_dout;
    bit [4:0] h_ss;
    bit [4:0] h_lp;
    bit [4:0] h_cl;

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    always @(posedge clk) begin
        bit p_ss, p_lp, p_cl, tk, live;
        int old_count;
        if (rst) begin
            m_mode = 0; m_count = 0; m_phase = 0; m_left = 0; m_snap = 0;
            exp_dout = 0;
            h_ss = '1; h_lp = '1; h_cl = '1;
        end else begin
            h_ss = {h_ss[3:0], b_ss};
            h_lp = {h_lp[3:0], b_lp};
            h_cl = {h_cl[3:0], b_cl};
            p_ss = h_ss[3] & ~h_ss[4];
            p_lp = h_lp[3] & ~h_lp[4];
            p_cl = h_cl[3] & ~h_cl[4];
            live = (m_mode == 1) || (m_mode == 3);
            tk = live && (m_phase == TICK_DIV - 1);
            m_phase = live ? (m_phase + 1) % TICK_DIV : 0;
            exp_dout = to_bcd((m_mode == 3) ? m_snap : m_count);
            old_count = m_count;
            if (p_cl) begin
                m_mode = 0; m_count = 0; m_left = 0;
            end else begin
                if (tk) m_count = (m_count + 1) % 100;
                if (m_mode == 0) begin
                    if (p_ss) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (p_ss) m_mode = 2;
                    else if (p_lp) begin m_mode = 3; m_snap = old_count; m_left = HOLD; end
                end else if (m_mode == 2) begin
                    if (p_ss) m_mode = 1;
                end else begin
                    if (p_ss) begin m_mode = 2; m_left = 0; end
                    else if (p_lp) begin m_snap = old_count; m_left = HOLD; end
                    else if (tk) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_mode = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_dout", dout, exp_dout);
            check("model_running", running, (m_mode == 1) || (m_mode == 3));
            check("model_lap", lap_active, m_mode == 3);
            check("bcd_units", dout[3:0] <= 4'd9, 1'b1);
            check("bcd_tens", dout[7:4] <= 4'd9, 1'b1);
        end
    end
`endif

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);
        check("reset_dout", dout, 8'h00);
        check("reset_running", running, 1'b0);
        check("reset_lap", lap_active, 1'b0);

`ifndef STOPWATCH_DEBOUNCE_EN
        // Start, first tick timing, 40 clocks of counting
        press(1'b1, 1'b0, 1'b0);
        wait_run("start_run", 1'b1, 20);
        cyc(4);
        check("first_tick_early", dout, 8'h00);
        cyc(1);
        check("first_tick", dout, 8'h01);
        cyc(36);
        check("run_40", dout, 8'h10);
        check("run_running", running, 1'b1);

        // Clear, then count up to the 99 -> 00 wrap
        press(1'b0, 1'b0, 1'b1);
        cyc(6);
        check("clear_dout", dout, 8'h00);
        check("clear_running", running, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        wait_dout("reach_98", 8'h98, 1000);
        wait_change(8'h98, 10);
        check("step_99", dout, 8'h99);
        wait_change(8'h99, 10);
        check("wrap_00", dout, 8'h00);

        // Lap hold at 05 while count reaches 08
        wait_dout("reach_04", 8'h04, 100);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (lap_active) break;
            cyc(1);
        end
        check("lap_enter", lap_active, 1'b1);
        check("lap_snapshot", dout, 8'h05);
        for (int i = 0; i < 100; i++) begin
            if (!lap_active) break;
            check("lap_hold", dout, 8'h05);
            cyc(1);
        end
        check("lap_expire", lap_active, 1'b0);
        cyc(1);
        check("lap_after", dout, 8'h08);
        check("lap_after_run", running, 1'b1);

        // All three buttons in the same cycle: clear wins
        press(1'b1, 1'b1, 1'b1);
        cyc(6);
        check("multi_dout", dout, 8'h00);
        check("multi_running", running, 1'b0);
        check("multi_lap", lap_active, 1'b0);

        // Pause at 07, hold, resume
        press(1'b1, 1'b0, 1'b0);
        wait_dout("reach_06", 8'h06, 100);
        press(1'b1, 1'b0, 1'b0);
        cyc(3);
        check("paused", running, 1'b0);
        for (int i = 0; i < 100; i++) begin
            check("pause_hold", dout, 8'h07);
            cyc(1);
        end
        press(1'b1, 1'b0, 1'b0);
        wait_run("resume", 1'b1, 20);
        cyc(4);
        check("resume_early", dout, 8'h07);
        cyc(1);
        check("resume_tick", dout, 8'h08);

        // Reset mid-run, then a button held through reset must not trigger
        cyc(10);
        rst = 1'b1;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_running", running, 1'b0);
        check("midrst_lap", lap_active, 1'b0);
        b_ss = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        check("held_no_retrigger", running, 1'b0);
        b_ss = 1'b0;
        cyc(5);
        press(1'b1, 1'b0, 1'b0);
        wait_run("press_after_release", 1'b1, 20);

        // Randomized activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) b_ss = ~b_ss;
            if ($urandom_range(0, 99) < 4) b_lp = ~b_lp;
            if ($urandom_range(0, 199) < 1) b_cl = ~b_cl;
            if ($urandom_range(0, 999) == 0) rst = 1'b1;
            else rst = 1'b0;
            cyc(1);
        end
        rst = 1'b0;
        b_ss = 1'b0;
        b_lp = 1'b0;
        b_cl = 1'b0;
        cyc(10);
`else
        begin
            int n;
            // Short glitch is rejected
            b_ss = 1'b1;
            cyc(5);
            b_ss = 1'b0;
            cyc(20);
            check("glitch_running", running, 1'b0);
            // Long press: RUN entered one clock after the press pulse
            b_ss = 1'b1;
            n = 0;
            for (int i = 0; i < 60; i++) begin
                if (running) break;
                cyc(1);
                n++;
            end
            check("debounce_latency", n, 4 + DEB);
            b_ss = 1'b0;
            cyc(20);
            check("debounce_running", running, 1'b1);
            rst = 1'b1;
            #1;
            check("midrst_dout", dout, 8'h00);
            check("midrst_running", running, 1'b0);
            check("midrst_lap", lap_active, 1'b0);
            cyc(2);
            rst = 1'b0;
            cyc(2);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
